// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cdb_arbiter
// Desc   : Round-robin Common Data Bus arbiter with flush gating and a
//          registered broadcast stage. Option macro: CDB_ARB_BRANCH_PRIORITY_EN
// Rev    : 1.0
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int BW_TAG            = 4,
    parameter int BW_PROCESSOR_DATA = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    input  logic [NUM_REQ*BW_TAG-1:0]            i_req_tag_flatten,
    input  logic [NUM_REQ*BW_PROCESSOR_DATA-1:0] i_req_data_flatten,
    input  logic                                 i_flush,
    output logic                                 o_cdb_valid,
    output logic [BW_TAG-1:0]                    o_cdb_tag,
    output logic [BW_PROCESSOR_DATA-1:0]         o_cdb_data,
    output logic [NUM_REQ-1:0]                   o_cdb_src
);

    localparam int                 c_ptr_w       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_ptr_w:0]   c_num_req     = (c_ptr_w+1)'(NUM_REQ);
    localparam logic [c_ptr_w-1:0] c_last_idx    = c_ptr_w'(NUM_REQ-1);
    localparam logic [NUM_REQ-1:0] c_branch_mask = NUM_REQ'(1);

    // Lowest index of the round-robin ring; with branch priority the ring
    // excludes requester 0, so the pointer resets to and wraps back to 1.
`ifdef CDB_ARB_BRANCH_PRIORITY_EN
    localparam logic [c_ptr_w-1:0] c_rr_base = c_ptr_w'(1);
`else
    localparam logic [c_ptr_w-1:0] c_rr_base = '0;
`endif

    logic [c_ptr_w-1:0]           rr_ptr_q;
    logic [c_ptr_w-1:0]           rr_ptr_d;
    logic                         cdb_valid_q;
    logic [BW_TAG-1:0]            cdb_tag_q;
    logic [BW_PROCESSOR_DATA-1:0] cdb_data_q;
    logic [NUM_REQ-1:0]           cdb_src_q;

    logic [NUM_REQ-1:0]           w_eligible;
    logic                         w_grant_any;
    logic [c_ptr_w-1:0]           w_grant_idx;
    logic [NUM_REQ-1:0]           w_grant_vec;
    logic                         w_moves_ptr;
    logic [BW_TAG-1:0]            w_sel_tag;
    logic [BW_PROCESSOR_DATA-1:0] w_sel_data;

    always_comb begin
        w_eligible = i_req_valid;
        if (i_flush) begin
            w_eligible = i_req_valid & c_branch_mask;
        end
    end

    always_comb begin
        logic [c_ptr_w:0] sum;
        sum         = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
`ifdef CDB_ARB_BRANCH_PRIORITY_EN
        if (w_eligible[0]) begin
            w_grant_any = 1'b1;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (c_ptr_w+1)'(i);
            if (sum >= c_num_req) begin
                sum = sum - (c_num_req - {1'b0, c_rr_base});
            end
            if (!w_grant_any && w_eligible[sum[c_ptr_w-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = sum[c_ptr_w-1:0];
            end
        end
    end

`ifdef CDB_ARB_BRANCH_PRIORITY_EN
    assign w_moves_ptr = w_grant_any && (w_grant_idx != '0);
`else
    assign w_moves_ptr = w_grant_any;
`endif

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_moves_ptr) begin
            if (w_grant_idx == c_last_idx) begin
                rr_ptr_d = c_rr_base;
            end else begin
                rr_ptr_d = w_grant_idx + c_ptr_w'(1);
            end
        end
    end

    assign w_grant_vec = w_grant_any ? (c_branch_mask << w_grant_idx) : '0;
    assign w_sel_tag   = i_req_tag_flatten[w_grant_idx*BW_TAG +: BW_TAG];
    assign w_sel_data  = i_req_data_flatten[w_grant_idx*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];

    // Ready is purely combinational, so it must be masked while reset is held.
    assign o_req_ready = rst_n ? w_grant_vec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= c_rr_base;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= 1'b0;
            // Tag 0 means "no dependency"; such a grant is consumed but never broadcast.
            if (w_grant_any && (w_sel_tag != '0)) begin
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= w_sel_tag;
                cdb_data_q  <= w_sel_data;
                cdb_src_q   <= w_grant_vec;
            end
        end
    end

    assign o_cdb_valid = cdb_valid_q;
    assign o_cdb_tag   = cdb_tag_q;
    assign o_cdb_data  = cdb_data_q;
    assign o_cdb_src   = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cdb_arbiter
// Desc   : Directed self-checking bench for cdb_arbiter.
// Rev    : 1.0
// ============================================================================
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BW_TAG  = 4;
    localparam int BW_DATA = 32;
`ifdef CDB_ARB_BRANCH_PRIORITY_EN
    localparam logic [1:0] c_rr_reset = 2'd1;
`else
    localparam logic [1:0] c_rr_reset = 2'd0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         i_req_valid;
    logic [NUM_REQ-1:0]         o_req_ready;
    logic [NUM_REQ*BW_TAG-1:0]  i_req_tag_flatten;
    logic [NUM_REQ*BW_DATA-1:0] i_req_data_flatten;
    logic                       i_flush;
    logic                       o_cdb_valid;
    logic [BW_TAG-1:0]          o_cdb_tag;
    logic [BW_DATA-1:0]         o_cdb_data;
    logic [NUM_REQ-1:0]         o_cdb_src;

    int n_pass  = 0;
    int n_total = 0;

    cdb_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .BW_TAG           (BW_TAG),
        .BW_PROCESSOR_DATA(BW_DATA)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_tag_flatten (i_req_tag_flatten),
        .i_req_data_flatten(i_req_data_flatten),
        .i_flush           (i_flush),
        .o_cdb_valid       (o_cdb_valid),
        .o_cdb_tag         (o_cdb_tag),
        .o_cdb_data        (o_cdb_data),
        .o_cdb_src         (o_cdb_src)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int k, input logic [3:0] tag, input logic [31:0] data);
        i_req_valid[k]                  = 1'b1;
        i_req_tag_flatten[k*4 +: 4]     = tag;
        i_req_data_flatten[k*32 +: 32]  = data;
    endtask

    task automatic clear_inputs();
        i_req_valid        = '0;
        i_req_tag_flatten  = '0;
        i_req_data_flatten = '0;
        i_flush            = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        set_req(0, 4'd1, 32'h11); set_req(1, 4'd2, 32'h22);
        set_req(2, 4'd3, 32'h33); set_req(3, 4'd4, 32'h44);
        #3;
        n_total++; if (o_req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (o_cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_cdb_valid); else n_pass++;
        n_total++; if (o_cdb_tag !== 4'd0) $display("FAIL reset_tag: got %h want 0", o_cdb_tag); else n_pass++;
        n_total++; if (o_cdb_data !== 32'd0) $display("FAIL reset_data: got %h want 0", o_cdb_data); else n_pass++;
        n_total++; if (o_cdb_src !== 4'b0000) $display("FAIL reset_src: got %b want 0000", o_cdb_src); else n_pass++;
        n_total++; if (dut.rr_ptr_q !== c_rr_reset) $display("FAIL reset_rr: got %0d want %0d", dut.rr_ptr_q, c_rr_reset); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 4'd5, 32'h1234);
        #1;
        n_total++; if (o_req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        i_req_valid = '0;
        n_total++; if (o_cdb_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", o_cdb_valid); else n_pass++;
        n_total++; if (o_cdb_tag !== 4'd5) $display("FAIL single_tag: got %h want 5", o_cdb_tag); else n_pass++;
        n_total++; if (o_cdb_data !== 32'h1234) $display("FAIL single_data: got %h want 1234", o_cdb_data); else n_pass++;
        n_total++; if (o_cdb_src !== 4'b0100) $display("FAIL single_src: got %b want 0100", o_cdb_src); else n_pass++;
        n_total++; if (dut.rr_ptr_q !== 2'd3) $display("FAIL single_rr: got %0d want 3", dut.rr_ptr_q); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (o_cdb_valid !== 1'b0) $display("FAIL single_idle_valid: got %b want 0", o_cdb_valid); else n_pass++;
        n_total++; if (o_cdb_tag !== 4'd5) $display("FAIL single_hold_tag: got %h want 5", o_cdb_tag); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 32'hA0 + 32'(k));
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++; if (o_req_ready !== (4'b0001 << c)) $display("FAIL rr_ready[%0d]: got %b want %b", c, o_req_ready, 4'b0001 << c); else n_pass++;
            @(posedge clk); #1;
            i_req_valid[c] = 1'b0;
            n_total++; if (o_cdb_valid !== 1'b1 || o_cdb_tag !== 4'(c + 1) || o_cdb_data !== 32'hA0 + 32'(c) || o_cdb_src !== (4'b0001 << c))
                $display("FAIL rr_bcast[%0d]: got v=%b tag=%h data=%h src=%b want v=1 tag=%h data=%h src=%b",
                         c, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src, 4'(c + 1), 32'hA0 + 32'(c), 4'b0001 << c);
            else n_pass++;
        end
        n_total++; if (dut.rr_ptr_q !== 2'd0) $display("FAIL rr_wrap: got %0d want 0", dut.rr_ptr_q); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        set_req(1, 4'd7, 32'h77);
        #1;
        n_total++; if (o_req_ready !== 4'b0010) $display("FAIL flush_pre_ready: got %b want 0010", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        i_req_valid = '0;
        i_flush = 1'b1;
        set_req(1, 4'd8, 32'h81);
        set_req(3, 4'd9, 32'h93);
        #1;
        n_total++; if (o_req_ready !== 4'b0000) $display("FAIL flush_block_ready: got %b want 0000", o_req_ready); else n_pass++;
        n_total++; if (o_cdb_valid !== 1'b1 || o_cdb_tag !== 4'd7) $display("FAIL flush_bus_live: got v=%b tag=%h want v=1 tag=7", o_cdb_valid, o_cdb_tag); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (o_cdb_valid !== 1'b0) $display("FAIL flush_no_bcast: got %b want 0", o_cdb_valid); else n_pass++;
        n_total++; if (dut.rr_ptr_q !== 2'd2) $display("FAIL flush_rr_hold: got %0d want 2", dut.rr_ptr_q); else n_pass++;
        set_req(0, 4'd10, 32'hA0);
        #1;
        n_total++; if (o_req_ready !== 4'b0001) $display("FAIL flush_br_ready: got %b want 0001", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        i_req_valid[0] = 1'b0;
        i_flush = 1'b0;
        n_total++; if (o_cdb_valid !== 1'b1 || o_cdb_src !== 4'b0001 || o_cdb_tag !== 4'd10)
            $display("FAIL flush_br_bcast: got v=%b src=%b tag=%h want v=1 src=0001 tag=a", o_cdb_valid, o_cdb_src, o_cdb_tag);
        else n_pass++;
        n_total++; if (dut.rr_ptr_q !== 2'd1) $display("FAIL flush_rr_adv: got %0d want 1", dut.rr_ptr_q); else n_pass++;
        #1;
        n_total++; if (o_req_ready !== 4'b0010) $display("FAIL post_flush_ready1: got %b want 0010", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        i_req_valid[1] = 1'b0;
        n_total++; if (o_cdb_tag !== 4'd8 || o_cdb_data !== 32'h81) $display("FAIL post_flush_bcast1: got tag=%h data=%h want tag=8 data=81", o_cdb_tag, o_cdb_data); else n_pass++;
        #1;
        n_total++; if (o_req_ready !== 4'b1000) $display("FAIL post_flush_ready3: got %b want 1000", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        i_req_valid[3] = 1'b0;
        n_total++; if (o_cdb_tag !== 4'd9 || o_cdb_src !== 4'b1000) $display("FAIL post_flush_bcast3: got tag=%h src=%b want tag=9 src=1000", o_cdb_tag, o_cdb_src); else n_pass++;
    endtask

    task automatic test_tag0();
        do_reset();
        set_req(1, 4'd0, 32'hDEAD);
        #1;
        n_total++; if (o_req_ready !== 4'b0010) $display("FAIL tag0_ready: got %b want 0010", o_req_ready); else n_pass++;
        @(posedge clk); #1;
        i_req_valid = '0;
        n_total++; if (o_cdb_valid !== 1'b0) $display("FAIL tag0_valid: got %b want 0", o_cdb_valid); else n_pass++;
        n_total++; if (o_cdb_data !== 32'd0) $display("FAIL tag0_data_hold: got %h want 0", o_cdb_data); else n_pass++;
        n_total++; if (dut.rr_ptr_q !== 2'd2) $display("FAIL tag0_rr: got %0d want 2", dut.rr_ptr_q); else n_pass++;
    endtask

    task automatic test_branch_priority();
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 32'hB0 + 32'(k));
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if (o_req_ready !== 4'b0001) $display("FAIL bp_hold_ready[%0d]: got %b want 0001", c, o_req_ready); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (o_cdb_src !== 4'b0001 || o_cdb_tag !== 4'd1) $display("FAIL bp_hold_bcast[%0d]: got src=%b tag=%h want src=0001 tag=1", c, o_cdb_src, o_cdb_tag); else n_pass++;
        end
        i_req_valid[0] = 1'b0;
        for (int c = 1; c < 4; c++) begin
            #1;
            n_total++; if (o_req_ready !== (4'b0001 << c)) $display("FAIL bp_rr_ready[%0d]: got %b want %b", c, o_req_ready, 4'b0001 << c); else n_pass++;
            @(posedge clk); #1;
            i_req_valid[c] = 1'b0;
            n_total++; if (o_cdb_tag !== 4'(c + 1)) $display("FAIL bp_rr_tag[%0d]: got %h want %h", c, o_cdb_tag, 4'(c + 1)); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(3, 4'd9, 32'h55);
        @(posedge clk); #1;
        i_req_valid = '0;
        n_total++; if (o_cdb_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b want 1", o_cdb_valid); else n_pass++;
        #3;
        rst_n = 1'b0;
        set_req(1, 4'd5, 32'h66);
        #1;
        n_total++; if (o_cdb_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", o_cdb_valid); else n_pass++;
        n_total++; if (o_cdb_tag !== 4'd0 || o_cdb_data !== 32'd0 || o_cdb_src !== 4'b0000)
            $display("FAIL areset_outs: got tag=%h data=%h src=%b want all 0", o_cdb_tag, o_cdb_data, o_cdb_src);
        else n_pass++;
        n_total++; if (o_req_ready !== 4'b0000) $display("FAIL areset_ready: got %b want 0000", o_req_ready); else n_pass++;
        n_total++; if (dut.rr_ptr_q !== c_rr_reset) $display("FAIL areset_rr: got %0d want %0d", dut.rr_ptr_q, c_rr_reset); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tag0();
`ifdef CDB_ARB_BRANCH_PRIORITY_EN
        test_branch_priority();
`else
        test_round_robin();
        test_flush();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
